clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - calendar clock with debounced mode/up/down field editor
// Button debouncer helper and clock_set_ctrl top live together in this file.

module clock_set_btn #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick1ms,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;

  // Count consecutive ms samples that disagree with the accepted level.
  // Any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      level_d <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_d <= level_q;
      if (tick1ms) begin
        if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign press = level_q & ~level_d;

endmodule

module clock_set_ctrl #(
  parameter int CNT1MS      = 100_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int MS_PER_SEC  = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] year,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic        edit,
  output logic [2:0]  edit_field,
  output logic        upd
);

  localparam int PW = (CNT1MS < 2) ? 1 : $clog2(CNT1MS);
  localparam int SW = (MS_PER_SEC < 2) ? 1 : $clog2(MS_PER_SEC);

  // State code doubles as the edit_field value.
  localparam logic [2:0] SET_YEAR  = 3'd0;
  localparam logic [2:0] SET_MONTH = 3'd1;
  localparam logic [2:0] SET_DAY   = 3'd2;
  localparam logic [2:0] SET_HOUR  = 3'd3;
  localparam logic [2:0] SET_MIN   = 3'd4;
  localparam logic [2:0] SET_SEC   = 3'd5;
  localparam logic [2:0] RUN       = 3'd7;

  function automatic logic [4:0] dim_of(input logic [11:0] y, input logic [3:0] m);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = ((y % 12'd4) == 12'd0) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  logic [PW-1:0] pre_q;
  logic          tick1ms;
  logic [SW-1:0] ms_q;
  logic [SW-1:0] ms_n;
  logic [2:0]    state_q;
  logic [2:0]    state_n;
  logic          mode_p;
  logic          up_p;
  logic          dn_p;
  logic [11:0]   year_n;
  logic [3:0]    month_n;
  logic [4:0]    day_n;
  logic [4:0]    hour_n;
  logic [5:0]    min_n;
  logic [5:0]    sec_n;
  logic [4:0]    dim_cur;
  logic [4:0]    dim_new;

  assign tick1ms = (pre_q == PW'(CNT1MS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q <= '0;
    end else if (tick1ms) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  clock_set_btn #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_mode (
    .clk(clk), .resetn(resetn), .tick1ms(tick1ms), .btn(btn_mode), .press(mode_p)
  );
  clock_set_btn #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_up (
    .clk(clk), .resetn(resetn), .tick1ms(tick1ms), .btn(btn_up), .press(up_p)
  );
  clock_set_btn #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_down (
    .clk(clk), .resetn(resetn), .tick1ms(tick1ms), .btn(btn_down), .press(dn_p)
  );

  always_comb begin
    state_n = state_q;
    ms_n    = ms_q;
    year_n  = year;
    month_n = month;
    day_n   = day;
    hour_n  = hour;
    min_n   = min;
    sec_n   = sec;
    dim_cur = dim_of(year, month);
    dim_new = 5'd31;

    if (mode_p) begin
      if (state_q == RUN)          state_n = SET_YEAR;
      else if (state_q == SET_SEC) state_n = RUN;
      else                         state_n = state_q + 3'd1;
    end

    if (state_q == RUN) begin
      if (tick1ms) begin
        if (ms_q == SW'(MS_PER_SEC - 1)) begin
          ms_n = '0;
          if (sec == 6'd59) begin
            sec_n = 6'd0;
            if (min == 6'd59) begin
              min_n = 6'd0;
              if (hour == 5'd23) begin
                hour_n = 5'd0;
                if (day >= dim_cur) begin
                  day_n = 5'd1;
                  if (month == 4'd12) begin
                    month_n = 4'd1;
                    year_n  = (year == 12'd2099) ? 12'd2000 : year + 12'd1;
                  end else begin
                    month_n = month + 4'd1;
                  end
                end else begin
                  day_n = day + 5'd1;
                end
              end else begin
                hour_n = hour + 5'd1;
              end
            end else begin
              min_n = min + 6'd1;
            end
          end else begin
            sec_n = sec + 6'd1;
          end
        end else begin
          ms_n = ms_q + 1'b1;
        end
      end
    end else begin
      ms_n = '0;
      // Mode wins over up/down; opposing up and down cancel.
      if (!mode_p && (up_p ^ dn_p)) begin
        case (state_q)
          SET_YEAR: begin
            if (up_p) year_n = (year == 12'd2099) ? 12'd2000 : year + 12'd1;
            else      year_n = (year == 12'd2000) ? 12'd2099 : year - 12'd1;
          end
          SET_MONTH: begin
            if (up_p) month_n = (month == 4'd12) ? 4'd1 : month + 4'd1;
            else      month_n = (month == 4'd1) ? 4'd12 : month - 4'd1;
          end
          SET_DAY: begin
            if (up_p) day_n = (day >= dim_cur) ? 5'd1 : day + 5'd1;
            else      day_n = (day <= 5'd1) ? dim_cur : day - 5'd1;
          end
          SET_HOUR: begin
            if (up_p) hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            else      hour_n = (hour == 5'd0) ? 5'd23 : hour - 5'd1;
          end
          SET_MIN: begin
            if (up_p) min_n = (min == 6'd59) ? 6'd0 : min + 6'd1;
            else      min_n = (min == 6'd0) ? 6'd59 : min - 6'd1;
          end
          SET_SEC: begin
            if (up_p) sec_n = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
            else      sec_n = (sec == 6'd0) ? 6'd59 : sec - 6'd1;
          end
          default: ;
        endcase
      end
    end

    // A year or month change can leave day beyond the new month length.
    dim_new = dim_of(year_n, month_n);
    if (day_n > dim_new) day_n = dim_new;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      ms_q    <= '0;
      year    <= 12'd2024;
      month   <= 4'd1;
      day     <= 5'd1;
      hour    <= 5'd0;
      min     <= 6'd0;
      sec     <= 6'd0;
      upd     <= 1'b0;
    end else begin
      state_q <= state_n;
      ms_q    <= ms_n;
      year    <= year_n;
      month   <= month_n;
      day     <= day_n;
      hour    <= hour_n;
      min     <= min_n;
      sec     <= sec_n;
      upd     <= ({year_n, month_n, day_n, hour_n, min_n, sec_n} !=
                  {year, month, day, hour, min, sec});
    end
  end

  assign edit       = (state_q != RUN);
  assign edit_field = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed bench for clock_set_ctrl (1 ms = 10 clk, 2 ms debounce, 5 ms second)

module tb_clock_set_ctrl;

  localparam logic [2:0] M = 3'b001;
  localparam logic [2:0] U = 3'b010;
  localparam logic [2:0] D = 3'b100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        btn_mode;
  logic        btn_up;
  logic        btn_down;
  logic [11:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        edit;
  logic [2:0]  edit_field;
  logic        upd;

  int vectors     = 0;
  int miscompares = 0;
  int upd_cnt     = 0;
  int upd_base    = 0;

  clock_set_ctrl #(.CNT1MS(10), .DEBOUNCE_MS(2), .MS_PER_SEC(5)) dut (
    .clk(clk), .resetn(resetn), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .year(year), .month(month), .day(day), .hour(hour), .min(min), .sec(sec),
    .edit(edit), .edit_field(edit_field), .upd(upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd === 1'b1) upd_cnt = upd_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_date(input string tag, input int y, input int mo, input int d);
    check({tag, ".year"}, 32'(year), 32'(y));
    check({tag, ".month"}, 32'(month), 32'(mo));
    check({tag, ".day"}, 32'(day), 32'(d));
  endtask

  task automatic check_reset(input string tag);
    check_date(tag, 2024, 1, 1);
    check({tag, ".hour"}, 32'(hour), 32'd0);
    check({tag, ".min"}, 32'(min), 32'd0);
    check({tag, ".sec"}, 32'(sec), 32'd0);
    check({tag, ".edit"}, 32'(edit), 32'd0);
    check({tag, ".edit_field"}, 32'(edit_field), 32'd7);
    check({tag, ".upd"}, 32'(upd), 32'd0);
  endtask

  // Hold the selected buttons, then release long enough to debounce the release.
  task automatic press(input logic [2:0] which, input int hold);
    @(negedge clk);
    btn_mode = which[0];
    btn_up   = which[1];
    btn_down = which[2];
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");

    // 50 ms idle: ten seconds elapse, one upd each
    resetn = 1'b1;
    repeat (505) @(negedge clk);
    check("idle.sec", 32'(sec), 32'd10);
    check("idle.min", 32'(min), 32'd0);
    check("idle.edit", 32'(edit), 32'd0);
    check("idle.upd_count", 32'(upd_cnt), 32'd10);

    // Preload 2023/12/31 23:59:59 and roll over one second
    do_reset();
    press(M, 25); press(D, 25);
    press(M, 25); press(D, 25);
    press(M, 25); press(D, 25);
    press(M, 25); press(D, 25);
    press(M, 25); press(D, 25);
    press(M, 25); press(D, 25);
    check_date("preload", 2023, 12, 31);
    check("preload.hour", 32'(hour), 32'd23);
    check("preload.min", 32'(min), 32'd59);
    check("preload.sec", 32'(sec), 32'd59);
    check("preload.edit_field", 32'(edit_field), 32'd5);
    upd_base = upd_cnt;
    press(M, 25);
    check("rollover.pre_sec", 32'(sec), 32'd59);
    repeat (40) @(negedge clk);
    check_date("rollover", 2024, 1, 1);
    check("rollover.hour", 32'(hour), 32'd0);
    check("rollover.min", 32'(min), 32'd0);
    check("rollover.sec", 32'(sec), 32'd0);
    check("rollover.edit_field", 32'(edit_field), 32'd7);
    check("rollover.upd_pulses", 32'(upd_cnt - upd_base), 32'd1);

    // Day clamping on year and month edits
    do_reset();
    press(M, 25); press(M, 25); press(U, 25);
    press(M, 25); press(D, 25);
    check_date("leap", 2024, 2, 29);
    repeat (5) press(M, 25);
    check("leap.back_to_year", 32'(edit_field), 32'd0);
    press(U, 25);
    check_date("clamp_year", 2025, 2, 28);
    press(M, 25); press(U, 25);
    press(M, 25); press(U, 25); press(U, 25); press(U, 25);
    check_date("mar31", 2025, 3, 31);
    repeat (6) press(M, 25);
    press(U, 25);
    check_date("clamp_month", 2025, 4, 30);

    // Glitch rejection, single press, no auto-repeat
    press(M, 25);
    upd_base = upd_cnt;
    press(U, 5);
    check("glitch.day", 32'(day), 32'd30);
    check("glitch.upd", 32'(upd_cnt - upd_base), 32'd0);
    press(U, 30);
    check("held3.day_wrap", 32'(day), 32'd1);
    check("held3.upd", 32'(upd_cnt - upd_base), 32'd1);
    press(U, 100);
    check("long_hold.day", 32'(day), 32'd2);

    // Hour wrap down, cancelling up+down, mode exit to RUN
    press(M, 25);
    check("set_hour.field", 32'(edit_field), 32'd3);
    check("set_hour.hour", 32'(hour), 32'd0);
    upd_base = upd_cnt;
    press(D, 25);
    check("hour_down.hour", 32'(hour), 32'd23);
    check("hour_down.upd", 32'(upd_cnt - upd_base), 32'd1);
    upd_base = upd_cnt;
    press(U | D, 25);
    check("up_dn.hour", 32'(hour), 32'd23);
    check("up_dn.upd", 32'(upd_cnt - upd_base), 32'd0);
    press(M, 25); press(M, 25);
    check("set_sec.field", 32'(edit_field), 32'd5);
    check("set_sec.edit", 32'(edit), 32'd1);
    press(M, 25);
    check("run.field", 32'(edit_field), 32'd7);
    check("run.edit", 32'(edit), 32'd0);

    // Up ignored in RUN, mode beats a coincident up
    press(U, 25);
    check_date("run_up", 2025, 4, 2);
    check("run_up.hour", 32'(hour), 32'd23);
    check("run_up.edit", 32'(edit), 32'd0);
    press(M, 25);
    press(M | U, 25);
    check("mode_up.field", 32'(edit_field), 32'd1);
    check("mode_up.year", 32'(year), 32'd2025);
    check("mode_up.month", 32'(month), 32'd4);
    press(M, 25); press(M, 25); press(M, 25);
    check("set_min.field", 32'(edit_field), 32'd4);

    // Asynchronous reset while editing
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset("reset_mid_edit");
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset.edit", 32'(edit), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
